// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM state
// encoding and the size-to-byte-count helper used by the access checker.
package lsu_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory control bundle of the load/store unit.
// The master side is the core/memory environment, the slave side is the unit itself.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_fault;
  logic [31:0]       rsp_rdata;

  logic [1:0]        MEM_write_length;
  logic [1:0]        MEM_read_length;
  logic              MEM_read_signed;
  logic [31:0]       MEM_write_address;
  logic [31:0]       MEM_read_address;
  logic [31:0]       MEM_write_data;
  logic [31:0]       MEM_read_data;

  modport master (
    output req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_fault, rsp_rdata,
    output rsp_ready,
    input  MEM_write_length, MEM_read_length, MEM_read_signed,
    input  MEM_write_address, MEM_read_address, MEM_write_data,
    output MEM_read_data
  );

  modport slave (
    input  req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_fault, rsp_rdata,
    input  rsp_ready,
    output MEM_write_length, MEM_read_length, MEM_read_signed,
    output MEM_write_address, MEM_read_address, MEM_write_data,
    input  MEM_read_data
  );

endinterface

// File: rtl/lsu_access_check.sv
// Combinational legality check for a memory access: illegal size, misalignment,
// or any byte of the access falling outside the attached memory.
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 100,
  parameter int ADDR_W    = 32
) (
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              fault_o
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [ADDR_W:0] endAddr;
  logic            misaligned;

  // One extra bit on the end address keeps accesses near the top of the address space from wrapping.
  always_comb begin
    endAddr    = {1'b0, addr_i} + {{(ADDR_W-2){1'b0}}, size_to_nbytes(size_i)};
    misaligned = 1'b0;
    case (size_i)
      SZ_HALF: misaligned = addr_i[0];
      SZ_WORD: misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault_o = (size_i == SZ_NONE) || misaligned || (endAddr > MEM_LIMIT);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, checks it, drives the data memory for a
// single ACCESS cycle and holds the response until the consumer takes it.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 100,
  parameter int ADDR_W    = 32
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  load_store_unit_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic              isStore_q, isStore_d;
  logic [1:0]        size_q, size_d;
  logic              isSigned_q, isSigned_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              fault_q, fault_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              reqFault;

  lsu_access_check #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_check (
    .size_i  (bus.req_size),
    .addr_i  (bus.req_addr),
    .fault_o (reqFault)
  );

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q    <= IDLE;
      isStore_q  <= 1'b0;
      size_q     <= SZ_NONE;
      isSigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      isStore_q  <= isStore_d;
      size_q     <= size_d;
      isSigned_q <= isSigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    isStore_d             = isStore_q;
    size_d                = size_q;
    isSigned_d            = isSigned_q;
    addr_d                = addr_q;
    wdata_d               = wdata_q;
    fault_d               = fault_q;
    rdata_d               = rdata_q;
    bus.req_ready         = 1'b0;
    bus.rsp_valid         = 1'b0;
    bus.MEM_write_length  = SZ_NONE;
    bus.MEM_read_length   = SZ_NONE;
    bus.MEM_read_signed   = 1'b0;
    bus.MEM_write_address = '0;
    bus.MEM_read_address  = '0;
    bus.MEM_write_data    = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          isStore_d  = bus.req_is_store;
          size_d     = bus.req_size;
          isSigned_d = bus.req_signed;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          fault_d    = reqFault;
          rdata_d    = '0;
          state_d    = reqFault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // Memory controls are masked during reset so an interrupted store never commits.
        if (!SYS_reset) begin
          if (isStore_q) begin
            bus.MEM_write_length  = size_q;
            bus.MEM_write_address = 32'(addr_q);
            bus.MEM_write_data    = wdata_q;
          end else begin
            bus.MEM_read_length  = size_q;
            bus.MEM_read_signed  = isSigned_q;
            bus.MEM_read_address = 32'(addr_q);
          end
        end
        rdata_d = isStore_q ? 32'h0 : bus.MEM_read_data;
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          fault_d = 1'b0;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_fault = fault_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-addressed memory model
// that commits writes at the clock edge and answers reads combinationally.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  int   writeCycles;
  int   wcBefore;

  logic        rFault;
  logic [31:0] rData;
  int          rLat;

  logic [7:0] mem [0:127];
  logic [6:0] rIdx0, rIdx1, rIdx2, rIdx3;
  logic [6:0] wIdx;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(
    .MEM_BYTES (100),
    .ADDR_W    (32)
  ) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Combinational read with the memory's own sign/zero extension.
  always_comb begin
    rIdx0 = bus.MEM_read_address[6:0];
    rIdx1 = rIdx0 + 7'd1;
    rIdx2 = rIdx0 + 7'd2;
    rIdx3 = rIdx0 + 7'd3;
    bus.MEM_read_data = 32'h0;
    case (bus.MEM_read_length)
      2'b01: bus.MEM_read_data = bus.MEM_read_signed ? {{24{mem[rIdx0][7]}}, mem[rIdx0]}
                                                     : {24'h0, mem[rIdx0]};
      2'b10: bus.MEM_read_data = bus.MEM_read_signed ? {{16{mem[rIdx1][7]}}, mem[rIdx1], mem[rIdx0]}
                                                     : {16'h0, mem[rIdx1], mem[rIdx0]};
      2'b11: bus.MEM_read_data = {mem[rIdx3], mem[rIdx2], mem[rIdx1], mem[rIdx0]};
      default: bus.MEM_read_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    wIdx = bus.MEM_write_address[6:0];
    if (bus.MEM_write_length != 2'b00) writeCycles++;
    case (bus.MEM_write_length)
      2'b01: mem[wIdx] = bus.MEM_write_data[7:0];
      2'b10: begin
        mem[wIdx]        = bus.MEM_write_data[7:0];
        mem[wIdx + 7'd1] = bus.MEM_write_data[15:8];
      end
      2'b11: begin
        mem[wIdx]        = bus.MEM_write_data[7:0];
        mem[wIdx + 7'd1] = bus.MEM_write_data[15:8];
        mem[wIdx + 7'd2] = bus.MEM_write_data[23:16];
        mem[wIdx + 7'd3] = bus.MEM_write_data[31:24];
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Full transaction from a negedge: returns fault, data and cycles from accept to rsp_valid.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic fault, output logic [31:0] rdata, output int lat);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_size     = sz;
    bus.req_signed   = sgn;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    fault = bus.rsp_fault;
    rdata = bus.rsp_rdata;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    checkCount       = 0;
    passCount        = 0;
    writeCycles      = 0;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_size     = SZ_NONE;
    bus.req_signed   = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[96] = 8'h44;
    mem[97] = 8'h33;
    mem[98] = 8'h22;
    mem[99] = 8'h11;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("rst_wlen", 32'(bus.MEM_write_length), 32'd0);
    checkOutput("rst_rlen", 32'(bus.MEM_read_length), 32'd0);

    wcBefore = writeCycles;
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'd8, 32'hDEADBEEF, rFault, rData, rLat);
    checkOutput("sw8_fault", 32'(rFault), 32'd0);
    checkOutput("sw8_rdata", rData, 32'h0);
    checkOutput("sw8_lat", 32'(rLat), 32'd2);
    checkOutput("sw8_wcycles", 32'(writeCycles - wcBefore), 32'd1);
    applyStimulus(1'b0, SZ_WORD, 1'b1, 32'd8, 32'h0, rFault, rData, rLat);
    checkOutput("lw8_fault", 32'(rFault), 32'd0);
    checkOutput("lw8_rdata", rData, 32'hDEADBEEF);
    checkOutput("lw8_lat", 32'(rLat), 32'd2);

    applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'd5, 32'h12345680, rFault, rData, rLat);
    checkOutput("sb5_fault", 32'(rFault), 32'd0);
    applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'd5, 32'h0, rFault, rData, rLat);
    checkOutput("lb5_signed", rData, 32'hFFFFFF80);
    applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'd5, 32'h0, rFault, rData, rLat);
    checkOutput("lbu5_unsigned", rData, 32'h00000080);

    wcBefore = writeCycles;
    applyStimulus(1'b0, SZ_HALF, 1'b0, 32'd3, 32'h0, rFault, rData, rLat);
    checkOutput("lh3_fault", 32'(rFault), 32'd1);
    checkOutput("lh3_rdata", rData, 32'h0);
    checkOutput("lh3_lat", 32'(rLat), 32'd1);
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'd6, 32'hA5A5A5A5, rFault, rData, rLat);
    checkOutput("sw6_fault", 32'(rFault), 32'd1);
    checkOutput("sw6_rdata", rData, 32'h0);
    checkOutput("sw6_lat", 32'(rLat), 32'd1);
    checkOutput("fault_wcycles", 32'(writeCycles - wcBefore), 32'd0);

    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd96, 32'h0, rFault, rData, rLat);
    checkOutput("lw96_fault", 32'(rFault), 32'd0);
    checkOutput("lw96_rdata", rData, 32'h11223344);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd97, 32'h0, rFault, rData, rLat);
    checkOutput("lw97_fault", 32'(rFault), 32'd1);
    applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'd99, 32'h0, rFault, rData, rLat);
    checkOutput("lb99_fault", 32'(rFault), 32'd0);
    checkOutput("lb99_rdata", rData, 32'h00000011);
    applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'd100, 32'h0, rFault, rData, rLat);
    checkOutput("lb100_fault", 32'(rFault), 32'd1);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFC, 32'h0, rFault, rData, rLat);
    checkOutput("lw_top_fault", 32'(rFault), 32'd1);
    applyStimulus(1'b0, SZ_NONE, 1'b0, 32'd0, 32'h0, rFault, rData, rLat);
    checkOutput("size0_fault", 32'(rFault), 32'd1);
    applyStimulus(1'b0, SZ_HALF, 1'b0, 32'd98, 32'h0, rFault, rData, rLat);
    checkOutput("lh98_rdata", rData, 32'h00001122);

    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_size     = SZ_WORD;
    bus.req_signed   = 1'b0;
    bus.req_addr     = 32'd8;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("acc_rlen", 32'(bus.MEM_read_length), 32'd3);
    checkOutput("acc_raddr", bus.MEM_read_address, 32'd8);
    checkOutput("acc_rsigned", 32'(bus.MEM_read_signed), 32'd0);
    checkOutput("acc_wlen", 32'(bus.MEM_write_length), 32'd0);
    checkOutput("acc_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_rlen", 32'(bus.MEM_read_length), 32'd0);
      checkOutput("bp_wlen", 32'(bus.MEM_write_length), 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(bus.req_ready), 32'd1);

    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_size     = SZ_WORD;
    bus.req_addr     = 32'd12;
    bus.req_wdata    = 32'hCAFEF00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("rstacc_wlen_pre", 32'(bus.MEM_write_length), 32'd3);
    wcBefore = writeCycles;
    rst = 1'b1;
    #1;
    checkOutput("rstacc_wlen", 32'(bus.MEM_write_length), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rstacc_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rstacc_wcycles", 32'(writeCycles - wcBefore), 32'd0);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd12, 32'h0, rFault, rData, rLat);
    checkOutput("rstacc_lw12", rData, 32'h0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
